// File: rtl/alu_pkg.sv
// Shared encodings, operation enum, pipeline stage record and sequence-age helper
// for the pipelined integer ALU.
package alu_pkg;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_SEQ_W  = 16;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

  localparam logic [2:0] FN3_ADD  = 3'b000;
  localparam logic [2:0] FN3_SLL  = 3'b001;
  localparam logic [2:0] FN3_SLT  = 3'b010;
  localparam logic [2:0] FN3_SLTU = 3'b011;
  localparam logic [2:0] FN3_XOR  = 3'b100;
  localparam logic [2:0] FN3_SR   = 3'b101;
  localparam logic [2:0] FN3_OR   = 3'b110;
  localparam logic [2:0] FN3_AND  = 3'b111;

  localparam logic [6:0] FN7_ZERO = 7'b0000000;
  localparam logic [6:0] FN7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI, ALU_AUIPC
  } alu_op_e;

  typedef struct packed {
    logic                  valid;
    logic [MAX_DATA_W-1:0] result;
    logic [MAX_SEQ_W-1:0]  seq;
    logic [6:0]            phy_dest;
    logic                  dest_valid;
    logic                  exception;
  } alu_stage_t;

  // a is younger than b when (a - b) mod 2^seq_w lies in [1, 2^(seq_w-1)).
  function automatic logic seq_younger(input logic [31:0] a, input logic [31:0] b,
                                       input int seq_w);
    logic [31:0] mask;
    logic [31:0] diff;
    mask = (32'd1 << seq_w) - 32'd1;
    diff = (a - b) & mask;
    return (diff != 32'd0) && (diff < (32'd1 << (seq_w - 1)));
  endfunction

endpackage

// File: rtl/alu_compute.sv
// Combinational decode-and-execute core: turns one raw instruction plus operands
// into a result, a destination-valid flag and an illegal-encoding flag.
module alu_compute
  import alu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int IMM_W  = 32
) (
  input  logic [31:0]       inst_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [IMM_W-1:0]  immd_i,
  input  logic              dest_valid_i,
  output logic [DATA_W-1:0] result_o,
  output logic              dest_valid_o,
  output logic              exception_o
);

  localparam bit IS_64 = (DATA_W == 64);

  alu_op_e           op;
  logic              is_w, use_imm, imm_shift, illegal;
  logic [6:0]        opcode, fn7, fn7_shift;
  logic [2:0]        fn3;
  logic [DATA_W-1:0] imm_ext, opb, res_full, res_w;
  logic [31:0]       a32, b32;
  logic [5:0]        sh;
  logic              unused_fields;

  assign unused_fields = ^{inst_i[19:15], inst_i[11:7]};

  function automatic logic [DATA_W-1:0] sext32(input logic [31:0] v);
    return DATA_W'($signed(v));
  endfunction

  assign opcode = inst_i[6:0];
  assign fn3    = inst_i[14:12];
  assign fn7    = inst_i[31:25];
  // fn7 bit 0 is shamt[5] for RV64 immediate shifts, so it is not part of the funct check there.
  assign fn7_shift = IS_64 ? {fn7[6:1], 1'b0} : fn7;

  always_comb begin
    op        = ALU_ADD;
    is_w      = 1'b0;
    use_imm   = 1'b0;
    imm_shift = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_LUI:   op = ALU_LUI;
      OPC_AUIPC: op = ALU_AUIPC;
      OPC_OP, OPC_OP_32: begin
        is_w = (opcode == OPC_OP_32);
        if (is_w && !IS_64) illegal = 1'b1;
        case (fn3)
          FN3_ADD: begin
            if (fn7 == FN7_ZERO)     op = ALU_ADD;
            else if (fn7 == FN7_ALT) op = ALU_SUB;
            else                     illegal = 1'b1;
          end
          FN3_SLL: begin
            op = ALU_SLL;
            if (fn7 != FN7_ZERO) illegal = 1'b1;
          end
          FN3_SR: begin
            if (fn7 == FN7_ZERO)     op = ALU_SRL;
            else if (fn7 == FN7_ALT) op = ALU_SRA;
            else                     illegal = 1'b1;
          end
          default: begin
            case (fn3)
              FN3_SLT:  op = ALU_SLT;
              FN3_SLTU: op = ALU_SLTU;
              FN3_XOR:  op = ALU_XOR;
              FN3_OR:   op = ALU_OR;
              default:  op = ALU_AND;
            endcase
            if (is_w || fn7 != FN7_ZERO) illegal = 1'b1;
          end
        endcase
      end
      OPC_OP_IMM: begin
        use_imm = 1'b1;
        case (fn3)
          FN3_ADD:  op = ALU_ADD;
          FN3_SLT:  op = ALU_SLT;
          FN3_SLTU: op = ALU_SLTU;
          FN3_XOR:  op = ALU_XOR;
          FN3_OR:   op = ALU_OR;
          FN3_AND:  op = ALU_AND;
          FN3_SLL: begin
            op        = ALU_SLL;
            imm_shift = 1'b1;
            if (fn7_shift != FN7_ZERO) illegal = 1'b1;
          end
          default: begin
            imm_shift = 1'b1;
            if (fn7_shift == FN7_ZERO)     op = ALU_SRL;
            else if (fn7_shift == FN7_ALT) op = ALU_SRA;
            else                           illegal = 1'b1;
          end
        endcase
      end
      OPC_OP_IMM_32: begin
        use_imm   = 1'b1;
        is_w      = 1'b1;
        imm_shift = (fn3 != FN3_ADD);
        if (!IS_64) illegal = 1'b1;
        if (fn3 == FN3_ADD)                          op = ALU_ADD;
        else if (fn3 == FN3_SLL && fn7 == FN7_ZERO)  op = ALU_SLL;
        else if (fn3 == FN3_SR && fn7 == FN7_ZERO)   op = ALU_SRL;
        else if (fn3 == FN3_SR && fn7 == FN7_ALT)    op = ALU_SRA;
        else                                         illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    imm_ext = DATA_W'($signed(immd_i));
    opb     = use_imm ? imm_ext : data2_i;
    sh      = imm_shift ? inst_i[25:20] : data2_i[5:0];
    if (is_w || !IS_64) sh[5] = 1'b0;
    a32      = data1_i[31:0];
    b32      = opb[31:0];
    res_full = '0;
    res_w    = '0;
    case (op)
      ALU_ADD:   res_full = data1_i + opb;
      ALU_SUB:   res_full = data1_i - opb;
      ALU_SLL:   res_full = data1_i << sh;
      ALU_SLT:   res_full = {{(DATA_W-1){1'b0}}, ($signed(data1_i) < $signed(opb))};
      ALU_SLTU:  res_full = {{(DATA_W-1){1'b0}}, (data1_i < opb)};
      ALU_XOR:   res_full = data1_i ^ opb;
      ALU_SRL:   res_full = data1_i >> sh;
      ALU_SRA:   res_full = $signed(data1_i) >>> sh;
      ALU_OR:    res_full = data1_i | opb;
      ALU_AND:   res_full = data1_i & opb;
      ALU_LUI:   res_full = imm_ext;
      ALU_AUIPC: res_full = pc_i + imm_ext;
      default:   res_full = '0;
    endcase
    // Word ops shift the 32-bit value itself so SRAW/SRAIW see bit 31 as the sign.
    case (op)
      ALU_ADD: res_w = sext32(a32 + b32);
      ALU_SUB: res_w = sext32(a32 - b32);
      ALU_SLL: res_w = sext32(a32 << sh[4:0]);
      ALU_SRL: res_w = sext32(a32 >> sh[4:0]);
      ALU_SRA: res_w = sext32($signed(a32) >>> sh[4:0]);
      default: res_w = '0;
    endcase
  end

  assign result_o     = illegal ? '0 : (is_w ? res_w : res_full);
  assign dest_valid_o = illegal ? 1'b0 : dest_valid_i;
  assign exception_o  = illegal;

endmodule

// File: rtl/pipelined_int_alu.sv
// Pipelined integer ALU: compute at entry, then PIPE_DEPTH result stages that advance
// together under valid/ready and drop entries younger than a mispredicted branch.
module pipelined_int_alu
  import alu_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int PIPE_DEPTH = 2,
  parameter int IMM_W      = 32,
  parameter int SEQ_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       inst_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic [IMM_W-1:0]  immd_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [SEQ_W-1:0]  seqNo_i,
  input  logic [6:0]        phyDest_i,
  input  logic              phyDestValid_i,
  input  logic              flush_i,
  input  logic [SEQ_W-1:0]  flushSeq_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic [SEQ_W-1:0]  seqNo_o,
  output logic [6:0]        phyDest_o,
  output logic              destValid_o,
  output logic              exception_o,
  output logic              executed_o
);

  logic [DATA_W-1:0] core_result;
  logic              core_dest_valid, core_exception;
  logic              adv;
  alu_stage_t        in_entry;
  alu_stage_t        stage_q [PIPE_DEPTH];
  alu_stage_t        stage_d [PIPE_DEPTH];

  alu_compute #(.DATA_W(DATA_W), .IMM_W(IMM_W)) u_compute (
    .inst_i      (inst_i),
    .data1_i     (data1_i),
    .data2_i     (data2_i),
    .pc_i        (pc_i),
    .immd_i      (immd_i),
    .dest_valid_i(phyDestValid_i),
    .result_o    (core_result),
    .dest_valid_o(core_dest_valid),
    .exception_o (core_exception)
  );

  assign adv        = !stage_q[PIPE_DEPTH-1].valid || out_ready_i;
  assign in_ready_o = adv;

  always_comb begin
    in_entry = '0;
    if (in_valid_i) begin
      in_entry.valid      = 1'b1;
      in_entry.result     = MAX_DATA_W'(core_result);
      in_entry.seq        = MAX_SEQ_W'(seqNo_i);
      in_entry.phy_dest   = phyDest_i;
      in_entry.dest_valid = core_dest_valid;
      in_entry.exception  = core_exception;
    end
  end

  // Shift or hold as a whole, then clear any surviving entry younger than the flush point.
  always_comb begin
    stage_d[0] = adv ? in_entry : stage_q[0];
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      stage_d[i] = adv ? stage_q[i-1] : stage_q[i];
    end
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if (flush_i && seq_younger(32'(stage_d[i].seq), 32'(flushSeq_i), SEQ_W)) begin
        stage_d[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if (reset) stage_q[i] <= '0;
      else       stage_q[i] <= stage_d[i];
    end
  end

  assign out_valid_o = stage_q[PIPE_DEPTH-1].valid;
  assign executed_o  = stage_q[PIPE_DEPTH-1].valid;
  assign result_o    = stage_q[PIPE_DEPTH-1].result[DATA_W-1:0];
  assign seqNo_o     = stage_q[PIPE_DEPTH-1].seq[SEQ_W-1:0];
  assign phyDest_o   = stage_q[PIPE_DEPTH-1].phy_dest;
  assign destValid_o = stage_q[PIPE_DEPTH-1].dest_valid;
  assign exception_o = stage_q[PIPE_DEPTH-1].exception;

endmodule
